// File: rtl/pwm_sync_multi_pkg.sv
// pwm_sync_multi_pkg: shared defaults and helpers for the edge-locked multi-channel PWM
package pwm_sync_multi_pkg;
   localparam int NCH_DEF    = 2;
   localparam int RES_DEF    = 4;
   localparam int CNT_W_DEF  = 24;
   localparam int SYNC_N_DEF = 2;
   function automatic int ch_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/pwm_sync_multi_sync_edge_detect.sv
// pwm_sync_multi_sync_edge_detect: synchronises an async input and flags its rising edges
module pwm_sync_multi_sync_edge_detect
   import pwm_sync_multi_pkg::*;
#(
   parameter int SYNC_N = SYNC_N_DEF
) (
   input  logic clock,
   input  logic i_reset_n,
   input  logic i_async,
   output logic o_rise
);
   logic [SYNC_N-1:0] sff;
   logic prev;
   always_ff @(posedge clock) begin
      if (!i_reset_n) begin
         sff  <= '0;
         prev <= 1'b0;
      end else begin
         sff  <= {sff[SYNC_N-2:0], i_async};
         prev <= sff[SYNC_N-1];
      end
   end
   assign o_rise = sff[SYNC_N-1] & ~prev;
endmodule

// File: rtl/pwm_sync_multi.sv
// pwm_sync_multi: measures the period of i_signal and drives NCH PWM outputs locked to its rising edges
module pwm_sync_multi
   import pwm_sync_multi_pkg::*;
#(
   parameter int NCH    = NCH_DEF,
   parameter int RES    = RES_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int SYNC_N = SYNC_N_DEF,
   localparam int CH_W  = ch_w(NCH)
) (
   input  logic             clock,
   input  logic             i_reset_n,
   input  logic             i_signal,
   input  logic             i_load,
   input  logic [CH_W-1:0]  i_ch,
   input  logic [RES-1:0]   i_duty,
   output logic [NCH-1:0]   o_pwm,
   output logic [CNT_W-1:0] o_period,
   output logic             o_valid,
   output logic             o_lost
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic edge_p, first_seen, sat, upd, tmo, valid_d;
   logic [CNT_W-1:0] cnt, cnt_inc;
   pwm_sync_multi_sync_edge_detect #(.SYNC_N(SYNC_N)) u_edge (
      .clock(clock),
      .i_reset_n(i_reset_n),
      .i_async(i_signal),
      .o_rise(edge_p)
   );
   always_comb begin
      sat     = cnt == CNT_MAX;
      cnt_inc = cnt + CNT_W'(1);
      upd     = edge_p & first_seen & ~sat;
      tmo     = sat & ~edge_p;
      valid_d = tmo ? 1'b0 : (upd | o_valid);
   end
   always_ff @(posedge clock) begin
      if (!i_reset_n) begin
         cnt        <= '0;
         o_period   <= '0;
         o_valid    <= 1'b0;
         o_lost     <= 1'b0;
         first_seen <= 1'b0;
      end else begin
         cnt        <= edge_p ? '0 : sat ? cnt : cnt_inc;
         o_valid    <= valid_d;
         o_lost     <= tmo | (o_lost & ~upd);
         first_seen <= edge_p | (first_seen & ~tmo);
         if (upd) o_period <= cnt_inc;
      end
   end
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [RES-1:0] shadow;
      logic [CNT_W-1:0] thr, thr_d, pos;
      logic [CNT_W+RES-1:0] prod;
      logic pwm;
      // position inside the window: 0 on the edge cycle, then cnt+1 tracks cycles already output
      always_comb begin
         prod  = {{RES{1'b0}}, cnt_inc} * {{CNT_W{1'b0}}, shadow};
         thr_d = edge_p ? CNT_W'(prod >> RES) : thr;
         pos   = edge_p ? '0 : cnt_inc;
      end
      always_ff @(posedge clock) begin
         if (!i_reset_n) begin
            shadow <= '0;
            thr    <= '0;
            pwm    <= 1'b0;
         end else begin
            if (i_load && i_ch == CH_W'(c)) shadow <= i_duty;
            thr <= thr_d;
            pwm <= valid_d && pos < thr_d;
         end
      end
      assign o_pwm[c] = pwm;
   end
endmodule

// File: tb/tb_pwm_sync_multi.sv
// tb_pwm_sync_multi: scoreboard bench counting PWM high cycles per input window
module tb_pwm_sync_multi;
   logic clock = 1'b0, i_reset_n = 1'b0, i_signal = 1'b0, i_load = 1'b0;
   logic [0:0] i_ch = '0;
   logic [3:0] i_duty = '0;
   logic [1:0] o_pwm;
   logic [7:0] o_period;
   logic o_valid, o_lost;
   pwm_sync_multi #(.NCH(2), .RES(4), .CNT_W(8), .SYNC_N(2)) dut (
      .clock(clock),
      .i_reset_n(i_reset_n),
      .i_signal(i_signal),
      .i_load(i_load),
      .i_ch(i_ch),
      .i_duty(i_duty),
      .o_pwm(o_pwm),
      .o_period(o_period),
      .o_valid(o_valid),
      .o_lost(o_lost)
   );
   always #10 clock = ~clock;
   typedef struct {int h0; int h1;} exp_t;
   exp_t exp_q[$];
   int checks = 0, failures = 0;
   logic [3:0] sig_d = '0;
   bit win_open = 0, seen = 0;
   int hi0 = 0, hi1 = 0, win_n = 0, gap = 0;
   int sh[2] = '{0, 0};
   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   // pin rise reaches o_pwm three samples later; sig_d marks that same sample as a window start
   task automatic tick();
      exp_t e;
      @(posedge clock);
      sig_d = {sig_d[2:0], i_signal};
      gap++;
      #1;
      if (sig_d[2] && !sig_d[3]) begin
         if (win_open) begin
            if (exp_q.size() == 0) check("scoreboard_empty", 1, 0);
            else begin
               e = exp_q.pop_front();
               check($sformatf("win%0d_ch0_high", win_n), hi0, e.h0);
               check($sformatf("win%0d_ch1_high", win_n), hi1, e.h1);
            end
            win_n++;
         end
         win_open = 1;
         hi0 = 0;
         hi1 = 0;
      end
      hi0 += int'(o_pwm[0]);
      hi1 += int'(o_pwm[1]);
   endtask
   task automatic load(input int ch, input int duty);
      i_load = 1'b1;
      i_ch = 1'(ch);
      i_duty = 4'(duty);
      sh[ch] = duty;
      tick();
      i_load = 1'b0;
   endtask
   task automatic drive_period(input int p, input int load_at = -1, input int lch = 0,
                               input int lduty = 0, input int rst_at = -1);
      exp_t e;
      bit v;
      int mp, t0, t1;
      mp = gap;
      v = seen && mp <= 255;
      gap = 0;
      t0 = v ? (mp * sh[0]) >> 4 : 0;
      t1 = v ? (mp * sh[1]) >> 4 : 0;
      e.h0 = t0 < p ? t0 : p;
      e.h1 = t1 < p ? t1 : p;
      exp_q.push_back(e);
      seen = 1;
      i_signal = 1'b1;
      for (int i = 0; i < p; i++) begin
         if (i == p / 2) i_signal = 1'b0;
         if (i == load_at) begin
            i_load = 1'b1;
            i_ch = 1'(lch);
            i_duty = 4'(lduty);
            sh[lch] = lduty;
         end
         if (i == load_at + 1) i_load = 1'b0;
         if (i == rst_at) begin
            check("pwm1_high_before_reset", int'(o_pwm[1]), 1);
            i_reset_n = 1'b0;
         end
         tick();
         if (i == rst_at) begin
            check("rst_pwm", int'(o_pwm), 0);
            check("rst_valid", int'(o_valid), 0);
            check("rst_period", int'(o_period), 0);
            check("rst_lost", int'(o_lost), 0);
            exp_q.delete();
            win_open = 0;
            sh = '{0, 0};
            seen = 0;
            gap = 0;
            v = 0;
            i_reset_n = 1'b1;
         end
      end
      i_load = 1'b0;
      check("valid_end_of_period", int'(o_valid), int'(v));
      if (v) check("period", int'(o_period), mp);
   endtask
   initial begin
      repeat (3) tick();
      i_reset_n = 1'b1;
      tick();
      check("reset_pwm", int'(o_pwm), 0);
      check("reset_period", int'(o_period), 0);
      check("reset_valid", int'(o_valid), 0);
      check("reset_lost", int'(o_lost), 0);
      load(0, 4);
      repeat (4) drive_period(160);
      drive_period(160, 100, 0, 0);
      drive_period(160, 100, 1, 15);
      repeat (3) drive_period(160);
      drive_period(160, 100, 1, 8);
      drive_period(160);
      drive_period(160, 2, 1, 15);
      repeat (2) drive_period(160);
      drive_period(160, 100, 0, 12);
      drive_period(160);
      repeat (4) drive_period(64);
      repeat (2) drive_period(160);
      check("lost_before_stop", int'(o_lost), 0);
      repeat (50) tick();
      check("valid_before_timeout", int'(o_valid), 1);
      repeat (250) tick();
      check("timeout_valid", int'(o_valid), 0);
      check("timeout_lost", int'(o_lost), 1);
      check("timeout_pwm", int'(o_pwm), 0);
      drive_period(160);
      check("lost_after_first_edge", int'(o_lost), 1);
      check("pwm_after_first_edge", int'(o_pwm), 0);
      drive_period(160);
      check("lost_after_second_edge", int'(o_lost), 0);
      drive_period(160);
      drive_period(160, -1, 0, 0, 100);
      repeat (2) drive_period(160);
      drive_period(160, 100, 0, 4);
      repeat (3) drive_period(160);
      repeat (8) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
